// File: rtl/mm_result_reader_pkg.sv
// Shared constants, state encoding and FIFO word type for the matrix-result reader.
// The MM_READER_CHECKSUM_EN build option uses CSUM_W from here.
package mm_result_reader_pkg;

    localparam int DEPTH  = 64;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 6;
    localparam int CSUM_W = DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } rd_word_t;

endpackage

// File: rtl/mm_reader_fifo.sv
// Two-entry FIFO holding returned result words with their address and last flag.
// Storage is cleared on reset so the head reads as zero until the first push.
module mm_reader_fifo
    import mm_result_reader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  rd_word_t   din_i,
    input  logic       pop_i,
    output rd_word_t   dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    rd_word_t   mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/mm_result_reader.sv
// Streams the 8x8 product matrix out of the result RAM in address order through a 2-entry FIFO.
// Define MM_READER_CHECKSUM_EN to add a signed running checksum of the transferred words.
module mm_result_reader
    import mm_result_reader_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    output logic                     ram_rd_en_o,
    output logic [ADDR_W-1:0]        ram_addr_o,
    input  logic [DATA_W-1:0]        ram_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [ADDR_W-1:0]        out_index_o,
    output logic                     out_last_o,
`ifdef MM_READER_CHECKSUM_EN
    output logic signed [CSUM_W-1:0] checksum_o,
`endif
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              prime_q;
    logic              dvld_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;

    rd_word_t          fifo_din;
    rd_word_t          fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [2:0]        used;
    logic              pop;
    logic              issue;
    logic              start_ok;

    assign start_ok = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i;
    assign pop      = !fifo_empty && out_ready_i;

    // Words held plus the one on the RAM bus; a word leaving this cycle frees a slot.
    assign used  = {1'b0, fifo_count} + {2'b00, dvld_q};
    assign issue = (state_q == ST_READ) && !prime_q && !fifo_full &&
                   (used < (3'd2 + {2'b00, pop}));

    assign fifo_din = '{last: (idx_q == LAST_ADDR), idx: idx_q, data: ram_data_i};

    mm_reader_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (dvld_q),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // prime_q idles the first READ cycle so the first word appears three cycles after start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            prime_q <= 1'b0;
            dvld_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            dvld_q <= issue;
            if (issue) begin
                idx_q <= addr_q;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q <= ST_READ;
                        addr_q  <= '0;
                        prime_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_READ: begin
                    prime_q <= 1'b0;
                    if (issue) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head.last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MM_READER_CHECKSUM_EN
    logic signed [CSUM_W-1:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + $signed({{ADDR_W{fifo_head.data[DATA_W-1]}}, fifo_head.data});
        end
    end

    assign checksum_o = csum_q;
`endif

    assign ram_rd_en_o = issue;
    assign ram_addr_o  = addr_q;
    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_head.data;
    assign out_index_o = fifo_head.idx;
    assign out_last_o  = fifo_head.last;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mm_result_reader.sv
// Directed bench for mm_result_reader: latency, stalls, mid-readout reset, restart from DONE,
// and (with MM_READER_CHECKSUM_EN) the signed checksum.
module tb_mm_result_reader;
    import mm_result_reader_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b1;
    logic              rd_en, out_valid, out_last, busy, done;
    logic [ADDR_W-1:0] addr, out_index;
    logic [DATA_W-1:0] ram_data = '0;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] ram [DEPTH];
`ifdef MM_READER_CHECKSUM_EN
    logic signed [CSUM_W-1:0] checksum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after the read strobe.
    always @(posedge clk) if (rd_en) ram_data <= ram[addr];

    mm_result_reader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .ram_rd_en_o (rd_en),
        .ram_addr_o  (addr),
        .ram_data_i  (ram_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_index_o (out_index),
        .out_last_o  (out_last),
`ifdef MM_READER_CHECKSUM_EN
        .checksum_o  (checksum),
`endif
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_addr"},  32'(addr), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data), 32'd0);
        chk({tag, "_index"}, 32'(out_index), 32'd0);
        chk({tag, "_last"},  32'(out_last), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
    endtask

    // Entered at the falling edge right after the start-sampling edge (k = 0).
    // mode 0: ready always high; mode 1: ready follows 1,0,0,1 per cycle.
    task automatic readout(input string tag, input int mode, input int stop_after, input bit timing);
        int                exp_idx = 0;
        int                first_v = -1;
        bit                got_done = 1'b0;
        bit                stall = 1'b0;
        bit                rdy;
        logic [3:0]        pat = 4'b1001;
        logic [25:0]       held = '0;
        for (int k = 0; k < 1000; k++) begin
            if (done) begin
                got_done = 1'b1;
                if (timing) chk({tag, "_done_cyc"}, 32'(k), 32'd67);
                break;
            end
            if (stall)
                chk({tag, "_hold"}, 32'({out_valid, out_last, out_index, out_data}), 32'({1'b1, held}));
            if (out_valid && first_v < 0) begin
                first_v = k;
                if (timing) chk({tag, "_lat"}, 32'(k), 32'd3);
            end
            rdy = (mode == 0) ? 1'b1 : pat[k % 4];
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (exp_idx < DEPTH) begin
                    chk({tag, "_idx"},  32'(out_index), 32'(exp_idx));
                    chk({tag, "_data"}, 32'(out_data), 32'(ram[exp_idx]));
                    chk({tag, "_last"}, 32'(out_last), 32'(exp_idx == DEPTH - 1));
                end else begin
                    chk({tag, "_extra"}, 32'd1, 32'd0);
                end
                exp_idx++;
            end
            stall = out_valid && !rdy;
            held  = {out_last, out_index, out_data};
            if (stop_after > 0 && exp_idx == stop_after) break;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (stop_after <= 0) begin
            chk({tag, "_count"}, 32'(exp_idx), 32'(DEPTH));
            chk({tag, "_done"},  32'(got_done), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i);
        #1 rst_n = 1'b0;
        #1 chk_zero("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Ascending data, ready always high.
        start = 1'b1; @(negedge clk); start = 1'b0;
        readout("seq", 0, -1, 1'b1);
        chk("seq_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("seq_done_hold", 32'(done), 32'd1);

        // Signed spread of values under a 1,0,0,1 ready pattern.
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i * 12345 - 200000);
        start = 1'b1; @(negedge clk); start = 1'b0;
        readout("stall", 1, -1, 1'b0);

        // Reset after 20 transfers, then a full readout from address 0.
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i);
        @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        readout("rst", 0, 20, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        repeat (2) @(negedge clk);
        chk_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        readout("rst2", 0, -1, 1'b1);

        // start held high: ignored while busy, restarts straight out of DONE.
        @(negedge clk);
        start = 1'b1; @(negedge clk);
        readout("hs1", 0, -1, 1'b1);
        @(negedge clk);
        chk("hs_done_drop", 32'(done), 32'd0);
        chk("hs_busy_rise", 32'(busy), 32'd1);
        start = 1'b0;
        readout("hs2", 0, -1, 1'b1);

        // Alternating full-scale values: pairs sum to -1, so 32 pairs give -32.
        for (int i = 0; i < DEPTH; i++) ram[i] = (i % 2 == 0) ? 19'h3FFFF : 19'h40000;
        @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        readout("alt", 0, -1, 1'b1);
`ifdef MM_READER_CHECKSUM_EN
        chk("alt_csum", 32'(checksum), 32'hFFFF_FFE0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
